wp_elastic_fifo: RTL

- Parametrised successor to the single-entry valid/retry flop stage used on directory-bank channel boundaries.
- Configurable-depth, configurable-width elastic buffer with registered valid/retry on both sides, so no combinational path crosses the block.
- Exposes occupancy for back-pressure monitoring.
- Optional drop-oldest mode for prefetch channels (l2todr_pfreq, drtomem_pfreq).

---
 rtl/wp_elastic_fifo_pkg.sv | 19 +
 rtl/wp_elastic_fifo_ptr.sv | 65 ++++++
 rtl/wp_elastic_fifo.sv | 73 +++++++
 3 files changed

// File: rtl/wp_elastic_fifo_pkg.sv
// Shared constants and occupancy types for the wp_elastic_fifo family.
// The WP_FIFO_DROP_OLDEST_EN macro selects drop-oldest mode in the fifo files.
package wp_elastic_fifo_pkg;

  localparam int WP_FIFO_DEPTH_DEFAULT = 4;

  // Occupancy holds 0..DEPTH inclusive, hence one bit more than the pointer.
  typedef logic [$clog2(2+1)-1:0]  fifo_count2_t;
  typedef logic [$clog2(4+1)-1:0]  fifo_count4_t;
  typedef logic [$clog2(8+1)-1:0]  fifo_count8_t;
  typedef logic [$clog2(16+1)-1:0] fifo_count16_t;
  typedef logic [$clog2(32+1)-1:0] fifo_count32_t;
  typedef logic [$clog2(64+1)-1:0] fifo_count64_t;

  function automatic int fifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wp_elastic_fifo_ptr.sv
// Pointer and occupancy bookkeeping for wp_elastic_fifo, shared by both modes.
// With WP_FIFO_DROP_OLDEST_EN a push into a full FIFO without a pop overwrites the oldest entry.
module wp_fifo_ptr
  import wp_elastic_fifo_pkg::*;
#(
  parameter int DEPTH = WP_FIFO_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = fifo_count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          drop
);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overwrite;
  logic          rd_adv;
  logic          count_inc;
  logic          count_dec;

`ifdef WP_FIFO_DROP_OLDEST_EN
  logic drop_reg;

  // When full, wr_ptr == rd_ptr, so the write slot is the oldest entry.
  assign overwrite = push && !pop && (count_reg == CW'(DEPTH));
  assign drop      = drop_reg;

  always_ff @(posedge clk) begin
    if (!reset) drop_reg <= 1'b0;
    else        drop_reg <= overwrite;
  end
`else
  assign overwrite = 1'b0;
  assign drop      = 1'b0;
`endif

  assign rd_adv    = pop || overwrite;
  assign count_inc = push && !pop && !overwrite;
  assign count_dec = pop && !push;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (count_inc)      count_reg <= count_reg + CW'(1);
      else if (count_dec) count_reg <= count_reg - CW'(1);
    end
  end

  assign wr_ptr = wr_ptr_reg;
  assign rd_ptr = rd_ptr_reg;
  assign count  = count_reg;

endmodule

// File: rtl/wp_elastic_fifo.sv
// Elastic valid/retry FIFO: all outputs come from registers, no input-to-output path.
// Define WP_FIFO_DROP_OLDEST_EN to replace back-pressure with drop-oldest overwrite.
module wp_elastic_fifo
  import wp_elastic_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = WP_FIFO_DEPTH_DEFAULT,
  parameter int CW    = fifo_count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             dinValid,
  output logic             dinRetry,
  output logic [WIDTH-1:0] q,
  output logic             qValid,
  input  logic             qRetry,
  output logic [CW-1:0]    count,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] wr_en;
  logic             push;
  logic             pop;

  wp_fifo_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_ptr (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .drop   (drop)
  );

`ifdef WP_FIFO_DROP_OLDEST_EN
  assign dinRetry = 1'b0;
`else
  assign dinRetry = (count == CW'(DEPTH));
`endif

  assign qValid = (count != '0);
  assign push   = reset && dinValid && !dinRetry;
  assign pop    = reset && qValid && !qRetry;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr == AW'(gi));
    end
  endgenerate

  // Storage is deliberately unreset; the output mask below keeps q clean when empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem[i] <= din;
    end
  end

  assign q = qValid ? mem[rd_ptr] : '0;

  a_din_valid_known: assert property (@(posedge clk) reset |-> !$isunknown(dinValid));

endmodule
